// File: rtl/ip_complex_initiator.sv
// ip_complex_initiator
// Drives the operand side of an ip_complex instance one transaction at a time.
// A request (req_a/req_b) is accepted in IDLE and registered onto ip_din_a/b.
// The block then waits for a rising edge on ip_ready, captures ip_dout_a/b and
// offers them on the response port. If no rising edge arrives within TIMEOUT
// cycles, an error response with zeroed data is returned instead.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   upstream request handshake
//   req_a[7:0], req_b[3:0] request operands
//   ip_din_a/ip_din_b     registered operands to the IP
//   ip_dout_a/ip_dout_b   IP results
//   ip_ready              IP result strobe (rising edge is significant)
//   rsp_valid/rsp_ready   downstream response handshake
//   rsp_a/rsp_b/rsp_err   response data and timeout flag
//   txn_count[CNT_W-1:0]  completed responses, wraps
//   err_count[7:0]        timeout responses, saturates at 255
module ip_complex_initiator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [3:0]       req_b,
  output logic [7:0]       ip_din_a,
  output logic [3:0]       ip_din_b,
  input  logic [7:0]       ip_dout_a,
  input  logic [3:0]       ip_dout_b,
  input  logic             ip_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_a,
  output logic [3:0]       rsp_b,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Last counter value before the timeout fires; the counter is 0 on the
  // first WAIT edge, so the timeout lands on the TIMEOUT-th WAIT edge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       ip_ready_q;
  logic       ip_rise;

  // Only IDLE can take a new request, so the handshake needs no extra state.
  assign req_ready = (state == ST_IDLE);

  // A level that was already high when WAIT began is not a rise, which is
  // what makes a stale ready time out instead of completing instantly.
  assign ip_rise = ip_ready && !ip_ready_q;

  // Main transaction FSM with registered operand, response and counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmo_cnt    <= 8'd0;
      ip_ready_q <= 1'b0;
      ip_din_a   <= 8'd0;
      ip_din_b   <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_a      <= 8'd0;
      rsp_b      <= 4'd0;
      rsp_err    <= 1'b0;
      txn_count  <= '0;
      err_count  <= 8'd0;
    end else begin
      ip_ready_q <= ip_ready;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ip_din_a <= req_a;
            ip_din_b <= req_b;
            tmo_cnt  <= 8'd0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A rise on the same edge as the timeout still counts as success.
          if (ip_rise) begin
            rsp_a     <= ip_dout_a;
            rsp_b     <= ip_dout_b;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_cnt == TMO_LAST) begin
              rsp_a     <= 8'd0;
              rsp_b     <= 4'd0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            txn_count <= txn_count + CNT_W'(1);
            if (rsp_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_complex_initiator.sv
// tb_ip_complex_initiator
// Randomized, scoreboard-checked bench for ip_complex_initiator. A simple IP
// model answers with the bitwise complement of its operands while ready is
// high and with noise otherwise. Each request pushes its expected response
// (data, error flag, latency) into a queue; a monitor on the falling edge pops
// and compares whenever a response is accepted, and tracks both counters.
module tb_ip_complex_initiator;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic       err;
    int         lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_a;
  logic [3:0]       req_b;
  logic [7:0]       ip_din_a;
  logic [3:0]       ip_din_b;
  logic [7:0]       ip_dout_a;
  logic [3:0]       ip_dout_b;
  logic             ip_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_a;
  logic [3:0]       rsp_b;
  logic             rsp_err;
  logic [CNT_W-1:0] txn_count;
  logic [7:0]       err_count;

  logic [7:0] junk_a;
  logic [3:0] junk_b;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   hs_cyc    = 0;
  int   first_cyc = 0;
  bit   seen      = 1'b0;
  int   model_txn = 0;
  int   model_err = 0;
  exp_t exp_q[$];

  ip_complex_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .ip_din_a  (ip_din_a),
    .ip_din_b  (ip_din_b),
    .ip_dout_a (ip_dout_a),
    .ip_dout_b (ip_dout_b),
    .ip_ready  (ip_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rsp_err   (rsp_err),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // IP model: valid results only while ready is high, noise otherwise, so a
  // capture on the wrong edge shows up as corrupted data.
  always @(posedge clk) begin
    junk_a <= 8'($urandom);
    junk_b <= 4'($urandom);
  end
  assign ip_dout_a = ip_ready ? ~ip_din_a : junk_a;
  assign ip_dout_b = ip_ready ? ~ip_din_b : junk_b;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request. k is the WAIT edge on which the IP ready rises
  // (0 = never), stale holds ready high throughout, hold is the number of
  // response cycles with rsp_ready low.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               input int k, input bit stale, input int hold);
    exp_t it;
    int   n;
    int   j;
    it.err = stale || (k == 0) || (k > TIMEOUT);
    it.a   = it.err ? 8'h00 : ~a;
    it.b   = it.err ? 4'h0 : ~b;
    it.lat = it.err ? TIMEOUT + 1 : k + 1;
    ip_ready  = stale;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    exp_q.push_back(it);
    @(posedge clk); #1;
    hs_cyc    = cyc;
    req_valid = 1'b0;
    req_a     = 8'($urandom);
    req_b     = 4'($urandom);
    checkOutput("ip_din_a_after_req", ip_din_a, a);
    checkOutput("ip_din_b_after_req", ip_din_b, b);
    j = 1;
    while (!rsp_valid && j <= TIMEOUT + 4) begin
      if (!stale) ip_ready = (j == k);
      req_valid = 1'($urandom_range(0, 1));
      req_a     = 8'($urandom);
      req_b     = 4'($urandom);
      @(posedge clk); #1; j++;
    end
    checkOutput("rsp_valid_within_bound", rsp_valid, 1);
    req_valid = 1'b0;
    if (!stale) ip_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_a", rsp_a, it.a);
      checkOutput("bp_rsp_b", rsp_b, it.b);
      checkOutput("bp_rsp_err", rsp_err, it.err);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_ip_din_a", ip_din_a, a);
      checkOutput("bp_ip_din_b", ip_din_b, b);
      req_valid = 1'b1;
      req_a     = 8'($urandom);
      req_b     = 4'($urandom);
      ip_ready  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    ip_ready  = stale;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("req_ready_after_rsp", req_ready, 1);
    checkOutput("rsp_valid_after_rsp", rsp_valid, 0);
    checkOutput("ip_din_a_hold", ip_din_a, a);
    checkOutput("ip_din_b_hold", ip_din_b, b);
  endtask

  // Reset while a transaction is waiting on the IP: everything clears at
  // once and the abandoned transaction never produces a response.
  task automatic applyResetInWait();
    ip_ready  = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 8'hC3;
    req_b     = 4'hA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ip_din_a", ip_din_a, 0);
    checkOutput("rst_async_ip_din_b", ip_din_b, 0);
    checkOutput("rst_async_req_ready", req_ready, 1);
    checkOutput("rst_async_rsp_valid", rsp_valid, 0);
    checkOutput("rst_async_txn_count", txn_count, 0);
    checkOutput("rst_async_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ip_ready = (i == 2);
      @(posedge clk); #1;
      checkOutput("rst_no_rsp_valid", rsp_valid, 0);
    end
    checkOutput("rst_txn_count_zero", txn_count, 0);
  endtask

  // Scoreboard monitor: compares counters every cycle and pops the expected
  // response when the response handshake is about to complete.
  always @(negedge clk) begin
    exp_t it;
    if (!rst_n) begin
      exp_q.delete();
      model_txn = 0;
      model_err = 0;
      seen      = 1'b0;
    end else begin
      checkOutput("txn_count", txn_count, model_txn);
      checkOutput("err_count", err_count, model_err);
      if (rsp_valid && !seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
        end else begin
          it = exp_q.pop_front();
          checkOutput("rsp_a", rsp_a, it.a);
          checkOutput("rsp_b", rsp_b, it.b);
          checkOutput("rsp_err", rsp_err, it.err);
          checkOutput("latency", first_cyc - hs_cyc + 1, it.lat);
          if (it.err && model_err < 255) model_err = model_err + 1;
        end
        model_txn = (model_txn + 1) % (1 << CNT_W);
        seen      = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends even if the DUT wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic and counter boundaries.
  initial begin
    int k;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = 8'd0;
    req_b     = 4'd0;
    ip_ready  = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_ip_din_a", ip_din_a, 0);
    checkOutput("reset_ip_din_b", ip_din_b, 0);
    checkOutput("reset_rsp_a", rsp_a, 0);
    checkOutput("reset_rsp_b", rsp_b, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_txn_count", txn_count, 0);
    checkOutput("reset_err_count", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic transaction");
    applyStimulus(8'hA5, 4'h3, 3, 1'b0, 0);
    checkOutput("basic_txn_count", txn_count, 1);

    $display("[TB] timeout");
    applyStimulus(8'h17, 4'h5, 0, 1'b0, 0);
    checkOutput("timeout_err_count", err_count, 1);

    $display("[TB] stale ready then normal");
    applyStimulus(8'h3C, 4'h9, 2, 1'b1, 0);
    applyStimulus(8'h81, 4'h6, 2, 1'b0, 0);

    $display("[TB] latency boundaries");
    applyStimulus(8'h00, 4'h0, 1, 1'b0, 0);
    applyStimulus(8'hFF, 4'hF, TIMEOUT, 1'b0, 0);
    applyStimulus(8'h42, 4'h7, TIMEOUT + 1, 1'b0, 0);

    $display("[TB] response backpressure");
    applyStimulus(8'h5F, 4'hE, 4, 1'b0, 10);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, TIMEOUT + 4);
      applyStimulus(8'($urandom), 4'($urandom), k, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("[TB] reset during wait");
    applyResetInWait();

    $display("[TB] txn_count wrap");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'($urandom), 4'($urandom), $urandom_range(1, TIMEOUT), 1'b0, $urandom_range(0, 1));
    end
    checkOutput("txn_count_wrapped", txn_count, 1);

    $display("[TB] err_count saturation");
    for (int i = 0; i < 257; i++) begin
      applyStimulus(8'($urandom), 4'($urandom), 0, 1'b0, 0);
    end
    checkOutput("err_count_saturated", err_count, 255);

    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
